// File: rtl/rvc_asap_pkg.sv
// Shared types and helpers for the rvc_asap data-memory path: access sizes,
// controller states, byte counts and two-word byte-lane enables.
package rvc_asap_pkg;

    typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2, SIZE_ILL = 2'd3} t_mem_size;
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP_ERR} t_dmem_state;

    function automatic logic [2:0] size_bytes(input t_mem_size size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Lanes [3:0] belong to the first word beat, [7:4] to the spill-over beat.
    function automatic logic [7:0] lane_en(input t_mem_size size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/rvc_dmem_ctrl_if.sv
// Request/response bus between the memory-access stage (master) and the
// data-memory controller (slave); one response per accepted request.
interface rvc_dmem_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrEn;
    logic [ADDR_W-1:0] ReqAddr;
    logic [1:0]        ReqSize;
    logic              ReqSignExt;
    logic [31:0]       ReqWrData;
    logic              RspValid;
    logic [31:0]       RspRdData;
    logic              RspErr;

    modport master (
        output ReqValid, ReqWrEn, ReqAddr, ReqSize, ReqSignExt, ReqWrData,
        input  ReqReady, RspValid, RspRdData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWrEn, ReqAddr, ReqSize, ReqSignExt, ReqWrData,
        output ReqReady, RspValid, RspRdData, RspErr
    );
endinterface

// File: rtl/rvc_dmem_array.sv
// Word-wide storage, byte-enabled synchronous write, asynchronous read; no reset.
// Behavioural stand-in for an SRAM macro with the same port shape.
module rvc_dmem_array #(
    parameter  int MEM_BYTES = 4096,
    localparam int IDX_W     = $clog2(MEM_BYTES) - 2
) (
    input  logic             Clock,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdat,
    output logic [31:0]      rdat
);
    logic [31:0] mem_q [MEM_BYTES/4];

    always_ff @(posedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_q[idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    assign rdat = mem_q[idx];
endmodule

// File: rtl/rvc_dmem_ctrl.sv
// Data-memory controller: WAIT_CYCLES+1 cycles per word beat, misaligned accesses split
// into two beats, range/size errors answered in 1 cycle; ReqReady low while busy.
module rvc_dmem_ctrl #(
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic           Clock,
    input  logic           Rst,
    rvc_dmem_ctrl_if.slave bus
);
    import rvc_asap_pkg::*;

    localparam int         ADDR_W    = $clog2(MEM_BYTES);
    localparam int         IDX_W     = ADDR_W - 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    t_dmem_state       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d, sx_q, sx_d;
    t_mem_size         size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdat_q, wdat_d, lo_q, lo_d;
    logic              rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;

    logic              req_err, beat_go, last_beat, misaligned;
    logic [ADDR_W:0]   req_end;
    logic [2:0]        req_n, n_q;
    logic [7:0]        lanes;
    logic [63:0]       wr_span, rd_span;
    logic [31:0]       rd_shift, ld_res;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [IDX_W-1:0]  mem_idx;
    logic [31:0]       mem_wdat, mem_rdat;

    // Carry out of addr+N-1 means the access runs past the top of memory.
    always_comb begin
        req_n   = size_bytes(t_mem_size'(bus.ReqSize));
        req_end = {1'b0, bus.ReqAddr} + {{(ADDR_W-2){1'b0}}, req_n - 3'd1};
        req_err = (bus.ReqSize == SIZE_ILL) || req_end[ADDR_W];
    end

    always_comb begin
        n_q        = size_bytes(size_q);
        misaligned = ({1'b0, addr_q[1:0]} + n_q) > 3'd4;
        lanes      = lane_en(size_q, addr_q[1:0]);
        wr_span    = {32'b0, wdat_q} << {addr_q[1:0], 3'b000};
        beat_go    = ((state_q == BEAT0) || (state_q == BEAT1)) && (cnt_q == 4'd0);
        last_beat  = beat_go && ((state_q == BEAT1) || !misaligned);
        mem_we     = beat_go && wr_q;
        mem_be     = (state_q == BEAT1) ? lanes[7:4] : lanes[3:0];
        mem_wdat   = (state_q == BEAT1) ? wr_span[63:32] : wr_span[31:0];
        mem_idx    = addr_q[ADDR_W-1:2] + {{(IDX_W-1){1'b0}}, state_q == BEAT1};
        rd_span    = (state_q == BEAT1) ? {mem_rdat, lo_q} : {32'b0, mem_rdat};
        rd_shift   = rd_span[{addr_q[1:0], 3'b000} +: 32];
        ld_res     = rd_shift;
        case (size_q)
            SIZE_B:  ld_res = sx_q ? {{24{rd_shift[7]}}, rd_shift[7:0]} : {24'b0, rd_shift[7:0]};
            SIZE_H:  ld_res = sx_q ? {{16{rd_shift[15]}}, rd_shift[15:0]} : {16'b0, rd_shift[15:0]};
            default: ld_res = rd_shift;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        sx_d      = sx_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        lo_d      = lo_q;
        rsp_vld_d = 1'b0;
        rsp_err_d = rsp_err_q;
        rsp_dat_d = rsp_dat_q;
        case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    wr_d    = bus.ReqWrEn;
                    sx_d    = bus.ReqSignExt;
                    size_d  = t_mem_size'(bus.ReqSize);
                    addr_d  = bus.ReqAddr;
                    wdat_d  = bus.ReqWrData;
                    state_d = req_err ? RESP_ERR : BEAT0;
                    cnt_d   = WAIT_INIT;
                end
            end
            BEAT0, BEAT1: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (state_q == BEAT0) begin
                        lo_d = mem_rdat;
                    end
                    if (last_beat) begin
                        state_d   = IDLE;
                        rsp_vld_d = 1'b1;
                        rsp_err_d = 1'b0;
                        rsp_dat_d = wr_q ? 32'b0 : ld_res;
                    end else begin
                        state_d = BEAT1;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            RESP_ERR: begin
                state_d   = IDLE;
                rsp_vld_d = 1'b1;
                rsp_err_d = 1'b1;
                rsp_dat_d = 32'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            sx_q      <= 1'b0;
            size_q    <= SIZE_B;
            addr_q    <= '0;
            wdat_q    <= 32'b0;
            lo_q      <= 32'b0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_dat_q <= 32'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            sx_q      <= sx_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            lo_q      <= lo_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_err_q <= rsp_err_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    rvc_dmem_array #(.MEM_BYTES(MEM_BYTES)) u_array (
        .Clock (Clock),
        .we    (mem_we),
        .be    (mem_be),
        .idx   (mem_idx),
        .wdat  (mem_wdat),
        .rdat  (mem_rdat)
    );

    assign bus.ReqReady  = (state_q == IDLE);
    assign bus.RspValid  = rsp_vld_q;
    assign bus.RspRdData = rsp_dat_q;
    assign bus.RspErr    = rsp_err_q;
endmodule
